get_dirc: RTL and testbench
===========================

// Module: get_dirc
// PURPOSE
//   Rotation-direction detector for the 10-position one-hot dial/keypad of the strong-box lock.
//   Tracks the last active position and reports the direction of the most recent single step.
//   The sequence checker advances on rising/falling edges of 'direction', i.e. on dial reversals.
// PARAMETERS
//   NPOS            10  number of dial positions (keypad width); positions 0..NPOS-1, cyclic
//   DEBOUNCE_CYCLES 4   consecutive identical samples needed before accept (GET_DIRC_DEBOUNCE_EN only)
// PORTS
//   clk        in   1     single clock; all state updates on rising edge
//   rst        in   1     synchronous, active-high reset
//   keypad     in   10    dial position, one-hot (bit k = dial at position k); asynchronous to clk
//   direction  out  1     1 = last step decreased position (k -> k-1), 0 = last step increased (k -> k+1)
//   pos        out  4     last accepted position 0..9
//   pos_valid  out  1     1 once a legal one-hot position has been accepted since reset
//   step       out  1     one-cycle pulse on each accepted adjacent step
//   err        out  1     one-cycle pulse when keypad sample is multi-hot or a non-adjacent jump
// BEHAVIOUR
//   - Reset (rst=1 at rising edge): direction=0, pos=0, pos_valid=0, step=0, err=0; synchronizer
//     and debounce state cleared (samples read as all-zero).
//   - keypad passes a 2-flop synchronizer; the accepted sample is the synchronizer output (or the
//     debounced value, see CONFIGURATION). Outputs are registered: a keypad change held steady is
//     reflected on outputs at the 3rd rising edge after it is applied (no debounce).
//   - Per accepted sample S, with p = pos:
//     * S all-zero: hold everything (dial between detents); step=err=0.
//     * S multi-hot: hold pos/direction/pos_valid; err=1 for one cycle.
//     * S one-hot at k, pos_valid=0: pos=k, pos_valid=1, direction unchanged, step=0.
//     * k == p: hold; no pulses (repeated samples of same position never generate steps).
//     * k == (p+1) mod 10: pos=k, direction=0, step=1. Wrap 9 -> 0 counts as increase.
//     * k == (p+9) mod 10: pos=k, direction=1, step=1. Wrap 0 -> 9 counts as decrease.
//     * any other k (jump >= 2): pos=k, direction unchanged, step=0, err=1.
//   - step/err are pulses only on the cycle the transition is accepted; 0 otherwise.
//   - direction only changes with step=1; a reversal (e.g. 3->4->3) gives a 0->1 edge at the
//     second step, so the dial position at the edge is the position just left -/+ 1.
//   - Mod-10 arithmetic done in 4 bits; pos never takes values 10..15.
//   - rst mid-operation overrides any pending transition in the same cycle.
// CONFIGURATION
//   GET_DIRC_DEBOUNCE_EN defined: the synchronized sample is accepted only after it has been
//     identical for DEBOUNCE_CYCLES consecutive clocks (counter restarts on any change); added
//     latency = DEBOUNCE_CYCLES clocks; glitches shorter than that are invisible (no step/err).
//   Not defined: synchronized sample accepted every clock; no debounce logic present.
// TESTING
//   - rst high 2 clks -> direction=0,pos=0,pos_valid=0,step=0,err=0; then keypad=10'b1 -> pos=0,pos_valid=1,step never pulses.
//   - keypad 0->1->2 (one-hot, each held 8 clks) -> two step pulses, direction=0, pos=2.
//   - keypad 3->4->3 -> direction 0 then rises to 1 on the second step, pos=3.
//   - wrap: 9->0 gives direction=0,step=1; 0->9 gives direction=1,step=1.
//   - keypad 10'b0000000101 -> err pulse, pos/direction unchanged; jump 2->6 -> pos=6, err=1, step=0, direction held.
//   - debounce build (DEBOUNCE_CYCLES=4): 2-clk glitch 5->6->5 -> no step/err; 6 held 4+ clks -> step=1,direction=0.

Source files
------------

// File: rtl/get_dirc.sv
// Rotation-direction detector for the one-hot strong-box dial.
// Optional input debounce is enabled by defining GET_DIRC_DEBOUNCE_EN.
module get_dirc #(
    parameter int NPOS            = 10,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NPOS-1:0] keypad,
    output logic            direction,
    output logic [3:0]      pos,
    output logic            pos_valid,
    output logic            step,
    output logic            err
);

    localparam logic [3:0] LAST = 4'(NPOS - 1);

    logic [NPOS-1:0] sync1;
    logic [NPOS-1:0] sync2;
    logic [NPOS-1:0] acc;
    logic [NPOS-1:0] last_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keypad;
            sync2 <= sync1;
        end
    end

`ifdef GET_DIRC_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NPOS-1:0] cand;
    logic [NPOS-1:0] deb;
    logic [CW-1:0]   cnt;

    // cand latches a new value; deb takes it once it has been seen
    // on DEBOUNCE_CYCLES consecutive clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand <= '0;
            deb  <= '0;
            cnt  <= '0;
        end else if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 2)) begin
            deb  <= cand;
            cnt  <= cnt + 1'b1;
        end else if (cnt < CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt  <= cnt + 1'b1;
        end
    end

    assign acc = deb;
`else
    assign acc = sync2;
`endif

    logic       zero;
    logic       multi;
    logic [3:0] k;
    logic [3:0] inc;
    logic [3:0] dec;

    always_comb begin
        k = '0;
        for (int i = 0; i < NPOS; i++) begin
            if (acc[i]) k = 4'(i);
        end
    end

    assign zero  = (acc == '0);
    assign multi = !zero && ((acc & (acc - 1'b1)) != '0);
    assign inc   = (pos == LAST) ? 4'd0 : pos + 4'd1;
    assign dec   = (pos == 4'd0) ? LAST : pos - 4'd1;

    logic       dir_n;
    logic [3:0] pos_n;
    logic       valid_n;
    logic       step_n;
    logic       err_n;

    always_comb begin
        dir_n   = direction;
        pos_n   = pos;
        valid_n = pos_valid;
        step_n  = 1'b0;
        err_n   = 1'b0;
        if (zero) begin
            err_n = 1'b0;
        end else if (multi) begin
            // A held multi-hot sample reports once, not every clock.
            err_n = (acc != last_acc);
        end else if (!pos_valid) begin
            pos_n   = k;
            valid_n = 1'b1;
        end else if (k == pos) begin
            step_n = 1'b0;
        end else if (k == inc) begin
            pos_n  = k;
            dir_n  = 1'b0;
            step_n = 1'b1;
        end else if (k == dec) begin
            pos_n  = k;
            dir_n  = 1'b1;
            step_n = 1'b1;
        end else begin
            pos_n = k;
            err_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            direction <= 1'b0;
            pos       <= '0;
            pos_valid <= 1'b0;
            step      <= 1'b0;
            err       <= 1'b0;
            last_acc  <= '0;
        end else begin
            direction <= dir_n;
            pos       <= pos_n;
            pos_valid <= valid_n;
            step      <= step_n;
            err       <= err_n;
            last_acc  <= acc;
        end
    end

endmodule

// File: tb/tb_get_dirc.sv
// Bench for get_dirc (default build): directed dial sequences plus
// random dial motion checked against a sample-level rule model.
module tb_get_dirc;

    localparam int NPOS = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NPOS-1:0] keypad = '0;
    logic            direction;
    logic [3:0]      pos;
    logic            pos_valid;
    logic            step;
    logic            err;

    int checks   = 0;
    int failures = 0;
    int steps_seen = 0;
    int errs_seen  = 0;

    // model state
    logic [NPOS-1:0] m_s1 = '0;
    logic [NPOS-1:0] m_s2 = '0;
    logic [NPOS-1:0] m_last = '0;
    int              m_pos = 0;
    logic            m_dir = 1'b0;
    logic            m_valid = 1'b0;
    logic            m_step = 1'b0;
    logic            m_err = 1'b0;

    get_dirc #(.NPOS(NPOS), .DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .keypad    (keypad),
        .direction (direction),
        .pos       (pos),
        .pos_valid (pos_valid),
        .step      (step),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic [NPOS-1:0] s);
        int n;
        int k;
        int d;
        m_step = 1'b0;
        m_err  = 1'b0;
        n = $countones(s);
        k = 0;
        for (int i = 0; i < NPOS; i++) if (s[i]) k = i;
        if (n > 1) begin
            m_err = (s != m_last);
        end else if (n == 1) begin
            if (!m_valid) begin
                m_pos   = k;
                m_valid = 1'b1;
            end else begin
                d = (k - m_pos + NPOS) % NPOS;
                if (d == 1) begin
                    m_dir = 1'b0;
                    m_step = 1'b1;
                end else if (d == NPOS - 1) begin
                    m_dir = 1'b1;
                    m_step = 1'b1;
                end else if (d != 0) begin
                    m_err = 1'b1;
                end
                m_pos = k;
            end
        end
        m_last = s;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
            m_last = '0;
            m_pos = 0;
            m_dir = 1'b0;
            m_valid = 1'b0;
            m_step = 1'b0;
            m_err = 1'b0;
        end else begin
            apply(m_s2);
            m_s2 = m_s1;
            m_s1 = keypad;
        end
        #1;
        steps_seen += int'(step);
        errs_seen  += int'(err);
        check("pos", int'(pos), m_pos);
        check("direction", int'(direction), int'(m_dir));
        check("pos_valid", int'(pos_valid), int'(m_valid));
        check("step", int'(step), int'(m_step));
        check("err", int'(err), int'(m_err));
    endtask

    task automatic hold(input logic [NPOS-1:0] v, input int n);
        keypad = v;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [NPOS-1:0] oh(input int k);
        logic [NPOS-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    initial begin
        int cp;
        int r;
        logic [NPOS-1:0] v;

        // reset values
        rst = 1'b1;
        hold('0, 2);
        check("rst_pos", int'(pos), 0);
        check("rst_valid", int'(pos_valid), 0);
        rst = 1'b0;

        // first position: valid, no step
        steps_seen = 0;
        hold(oh(0), 2);
        check("lat_valid_early", int'(pos_valid), 0);
        tick();
        check("lat_valid_3rd", int'(pos_valid), 1);
        hold(oh(0), 5);
        check("first_no_step", steps_seen, 0);

        // 0 -> 1 -> 2 increasing
        steps_seen = 0;
        hold(oh(1), 8);
        hold(oh(2), 8);
        check("inc_steps", steps_seen, 2);
        check("inc_dir", int'(direction), 0);
        check("inc_pos", int'(pos), 2);

        // 3 -> 4 -> 3 reversal
        hold(oh(3), 8);
        hold(oh(4), 8);
        check("rev_dir0", int'(direction), 0);
        hold(oh(3), 8);
        check("rev_dir1", int'(direction), 1);
        check("rev_pos", int'(pos), 3);

        // wraps 9 -> 0 and 0 -> 9
        hold(oh(2), 4);
        hold(oh(9), 8);
        hold(oh(0), 8);
        check("wrap_inc_dir", int'(direction), 0);
        hold(oh(9), 8);
        check("wrap_dec_dir", int'(direction), 1);
        check("wrap_dec_pos", int'(pos), 9);

        // multi-hot: one err pulse, state held
        errs_seen = 0;
        hold(10'b0000000101, 8);
        check("multi_err_once", errs_seen, 1);
        check("multi_pos", int'(pos), 9);

        // jump 2 -> 6
        hold(oh(1), 8);
        hold(oh(2), 8);
        errs_seen = 0;
        steps_seen = 0;
        hold(oh(6), 8);
        check("jump_pos", int'(pos), 6);
        check("jump_err", errs_seen, 1);
        check("jump_step", steps_seen, 0);
        check("jump_dir", int'(direction), 0);

        // reset while a transition is in the synchronizer
        hold(oh(7), 2);
        rst = 1'b1;
        hold(oh(7), 1);
        rst = 1'b0;
        check("midrst_pos", int'(pos), 0);

        // random dial motion
        cp = 7;
        for (int seg = 0; seg < 400; seg++) begin
            r = $urandom_range(0, 11);
            if (r <= 3) cp = (cp + 1) % NPOS;
            else if (r <= 6) cp = (cp + NPOS - 1) % NPOS;
            else if (r == 9) cp = $urandom_range(0, NPOS - 1);
            v = oh(cp);
            if (r == 7) v = '0;
            if (r == 8) v = oh(cp) | oh((cp + 3) % NPOS);
            if (r == 10) v = NPOS'($urandom);
            rst = (r == 11) && ($urandom_range(0, 3) == 0);
            hold(v, $urandom_range(1, 5));
            rst = 1'b0;
        end
        hold('0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
